// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
package adder_pkg;

  localparam int ADDER_MAX_N = 64;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } adder_flags_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder cell for the ripple chain.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic p;

  assign p      = a_i ^ b_i;
  assign s_o    = p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/ripple_adder_reg.sv
// N-bit ripple-carry adder with registered sum, carry, overflow and zero flags.
// One cycle of latency, one result per cycle, no back-pressure.
module ripple_adder_reg
  import adder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow,
  output logic         zero
);

  logic [N:0]   c;
  logic [N-1:0] sum_d, sum_q;
  adder_flags_t flags_d, flags_q;
  logic         vld_q;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder_bit u_fa (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .cin_i  (c[i]),
      .s_o    (sum_d[i]),
      .cout_o (c[i+1])
    );
  end

  // For N=1, c[N-1] is cin, so the same expression covers the single-bit case.
  always_comb begin
    flags_d          = '0;
    flags_d.cout     = c[N];
    flags_d.overflow = c[N] ^ c[N-1];
    flags_d.zero     = (sum_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = vld_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_ripple_adder_reg.sv
// Directed and randomised checks of ripple_adder_reg at N=4 and N=8.
module tb_ripple_adder_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv4, cin4, ov4, co4, of4, z4;
  logic [3:0] a4, b4, s4;
  logic       iv8, cin8, ov8, co8, of8, z8;
  logic [7:0] a8, b8, s8;

  int n_tests = 0;
  int n_fail  = 0;

  ripple_adder_reg #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .sum(s4), .cout(co4), .overflow(of4), .zero(z4)
  );

  ripple_adder_reg #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .cout(co8), .overflow(of8), .zero(z8)
  );

  // Observed outputs packed as {out_valid, sum, cout, overflow, zero}
  function automatic logic [7:0] obs4();
    return {ov4, s4, co4, of4, z4};
  endfunction

  function automatic logic [11:0] obs8();
    return {ov8, s8, co8, of8, z8};
  endfunction

  task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
    a4 = a; b4 = b; cin4 = c; iv4 = v; iv8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic apply8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    a8 = a; b8 = b; cin8 = c; iv8 = v; iv4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    #12;
    n_tests++;
    if (obs4() !== 8'b0) begin
      n_fail++; $display("FAIL reset_state4 got %b want %b", obs4(), 8'b0);
    end
    n_tests++;
    if (obs8() !== 12'b0) begin
      n_fail++; $display("FAIL reset_state8 got %b want %b", obs8(), 12'b0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (obs4() !== 8'b0) begin
      n_fail++; $display("FAIL idle_after_reset4 got %b want %b", obs4(), 8'b0);
    end
  endtask

  task automatic test_add_basic();
    logic [3:0] ta [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    logic [3:0] tb [4] = '{4'b0101, 4'b1101, 4'b0000, 4'b1111};
    logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] te [4] = '{8'b1_1000_010, 8'b1_0100_100, 8'b1_0000_101, 8'b1_1111_100};
    for (int i = 0; i < 4; i++) begin
      apply4(ta[i], tb[i], tc[i], 1'b1);
      n_tests++;
      if (obs4() !== te[i]) begin
        n_fail++; $display("FAIL add_basic[%0d] got %b want %b", i, obs4(), te[i]);
      end
    end
  endtask

  task automatic test_add8_boundary();
    logic [7:0]  ta [3] = '{8'hff, 8'h00, 8'h7f};
    logic [7:0]  tb [3] = '{8'hff, 8'h00, 8'h01};
    logic        tc [3] = '{1'b1, 1'b0, 1'b0};
    logic [11:0] te [3] = '{12'b1_11111111_100, 12'b1_00000000_001, 12'b1_10000000_010};
    for (int i = 0; i < 3; i++) begin
      apply8(ta[i], tb[i], tc[i], 1'b1);
      n_tests++;
      if (obs8() !== te[i]) begin
        n_fail++; $display("FAIL add8_boundary[%0d] got %b want %b", i, obs8(), te[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply4(4'b0011, 4'b0101, 1'b0, 1'b1);
    n_tests++;
    if (obs4() !== 8'b1_1000_010) begin
      n_fail++; $display("FAIL pre_async_reset got %b want %b", obs4(), 8'b1_1000_010);
    end
    iv4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (obs4() !== 8'b0) begin
      n_fail++; $display("FAIL async_reset4 got %b want %b", obs4(), 8'b0);
    end
    n_tests++;
    if (obs8() !== 12'b0) begin
      n_fail++; $display("FAIL async_reset8 got %b want %b", obs8(), 12'b0);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ta [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b1010, 4'b0110};
    logic [3:0] tb [5] = '{4'b0001, 4'b0100, 4'b1000, 4'b0101, 4'b0011};
    logic       tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] te [5] = '{8'b1_0010_000, 8'b1_1001_010, 8'b1_0000_111,
                           8'b0_0000_111, 8'b0_0000_111};
    for (int i = 0; i < 5; i++) begin
      apply4(ta[i], tb[i], tc[i], tv[i]);
      n_tests++;
      if (obs4() !== te[i]) begin
        n_fail++; $display("FAIL back_to_back[%0d] got %b want %b", i, obs4(), te[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  e5;
    logic [8:0]  e9;
    logic        eo;
    logic [7:0]  x4;
    logic [11:0] x8;
    for (int i = 0; i < 1000; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); iv4 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); iv8 = 1'b1;
      @(posedge clk); #1;
      e5 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      eo = (a4[3] == b4[3]) && (e5[3] != a4[3]);
      x4 = {1'b1, e5[3:0], e5[4], eo, e5[3:0] == 4'b0};
      n_tests++;
      if (obs4() !== x4) begin
        n_fail++;
        $display("FAIL random4 a=%h b=%h cin=%b got %b want %b", a4, b4, cin4, obs4(), x4);
      end
      e9 = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
      eo = (a8[7] == b8[7]) && (e9[7] != a8[7]);
      x8 = {1'b1, e9[7:0], e9[8], eo, e9[7:0] == 8'b0};
      n_tests++;
      if (obs8() !== x8) begin
        n_fail++;
        $display("FAIL random8 a=%h b=%h cin=%b got %b want %b", a8, b8, cin8, obs8(), x8);
      end
    end
    iv4 = 1'b0; iv8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add8_boundary();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
